// File: rtl/shift_seq_unit.sv
// shift_seq_unit
//   Iterative, mode-selectable shifter for the MDR datapath. An accepted
//   request is shifted by up to STEP bits per cycle until the requested
//   amount is consumed, then the result is published on o_val with a
//   one-cycle o_done pulse.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_IDLE  | waiting for i_start; o_busy=0
//   S_SHIFT | consuming cnt, up to STEP bits per cycle
//   S_DONE  | o_done pulse; o_val valid; back to S_IDLE next cycle
//
// Ports
//   clk      clock, all logic on posedge
//   rst      synchronous reset, active-high
//   i_start  request, accepted only in S_IDLE
//   i_val    operand, sampled on the accept cycle
//   i_amt    shift amount 0..DW-1, sampled on the accept cycle
//   i_mode   00 LSL, 01 LSR, 10 ASR, 11 ROL, sampled on the accept cycle
//   o_busy   high in S_SHIFT and S_DONE
//   o_done   one-cycle completion pulse
//   o_val    result register, held until the next completion

module shift_seq_unit #(
  parameter int DW   = 32,
  parameter int STEP = 1,
  parameter int AW   = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [DW-1:0] i_val,
  input  logic [AW-1:0] i_amt,
  input  logic [1:0]    i_mode,
  output logic          o_busy,
  output logic          o_done,
  output logic [DW-1:0] o_val
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  state_t        state, state_nxt;
  logic [DW-1:0] dreg, dreg_nxt;
  logic [DW-1:0] val_q, val_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic [1:0]    mode, mode_nxt;
  logic [AW-1:0] step_amt;
  logic [AW-1:0] cnt_rem;
  logic [DW-1:0] shifted;

  function automatic logic [DW-1:0] shift_op(input logic [DW-1:0] d,
                                             input logic [AW-1:0] s,
                                             input logic [1:0]    m);
    logic [2*DW-1:0] dbl;
    logic [DW-1:0]   r;
    // Rotate: shift a doubled copy; the upper half holds the rotated word.
    dbl = {d, d} << s;
    case (m)
      2'b00:   r = d << s;
      2'b01:   r = d >> s;
      2'b10:   r = DW'($signed(d) >>> s);
      default: r = dbl[2*DW-1:DW];
    endcase
    return r;
  endfunction

  // Last partial step when the remaining count is below STEP.
  assign step_amt = (cnt < STEP_W) ? cnt : STEP_W;
  assign cnt_rem  = cnt - step_amt;
  assign shifted  = shift_op(dreg, step_amt, mode);

  always_comb begin
    state_nxt = state;
    dreg_nxt  = dreg;
    cnt_nxt   = cnt;
    mode_nxt  = mode;
    val_nxt   = val_q;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          dreg_nxt = i_val;
          cnt_nxt  = i_amt;
          mode_nxt = i_mode;
          if (i_amt == '0) begin
            val_nxt   = i_val;
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        dreg_nxt = shifted;
        cnt_nxt  = cnt_rem;
        if (cnt_rem == '0) begin
          val_nxt   = shifted;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      dreg  <= '0;
      cnt   <= '0;
      mode  <= '0;
      val_q <= '0;
    end else begin
      state <= state_nxt;
      dreg  <= dreg_nxt;
      cnt   <= cnt_nxt;
      mode  <= mode_nxt;
      val_q <= val_nxt;
    end
  end

  assign o_busy = (state != S_IDLE);
  assign o_done = (state == S_DONE);
  assign o_val  = val_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Bench for shift_seq_unit: one instance with STEP=1 and one with STEP=4,
// sharing operands but with separate start strobes.

module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start1, start4;
  logic [31:0] val;
  logic [4:0]  amt;
  logic [1:0]  mode;
  logic        busy1, done1, busy4, done4;
  logic [31:0] oval1, oval4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_seq_unit #(.DW(32), .STEP(1)) u_s1 (
    .clk(clk), .rst(rst), .i_start(start1), .i_val(val), .i_amt(amt),
    .i_mode(mode), .o_busy(busy1), .o_done(done1), .o_val(oval1)
  );

  shift_seq_unit #(.DW(32), .STEP(4)) u_s4 (
    .clk(clk), .rst(rst), .i_start(start4), .i_val(val), .i_amt(amt),
    .i_mode(mode), .o_busy(busy4), .o_done(done4), .o_val(oval4)
  );

  typedef struct {
    logic [31:0] v;
    logic [4:0]  n;
    logic [1:0]  m;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  // Bit-level reference: each result bit is picked from its source position.
  function automatic logic [31:0] model(input logic [31:0] v, input int n, input logic [1:0] m);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      case (m)
        2'b00:   r[i] = (i >= n) ? v[i-n] : 1'b0;
        2'b01:   r[i] = (i + n < 32) ? v[i+n] : 1'b0;
        2'b10:   r[i] = (i + n < 32) ? v[i+n] : v[31];
        default: r[i] = v[(i - n + 32) % 32];
      endcase
    end
    return r;
  endfunction

  task automatic run_op(input logic [31:0] v, input logic [4:0] n, input logic [1:0] m,
                        input logic [31:0] exp, input int lat1, input int lat4,
                        input string name);
    int seen1, seen4, p1, p4, mx;
    logic [31:0] cap1, cap4;
    seen1 = 0; seen4 = 0; p1 = 0; p4 = 0;
    cap1 = '0; cap4 = '0;
    mx = (lat1 > lat4) ? lat1 : lat4;
    @(negedge clk);
    val = v; amt = n; mode = m; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start4 = 1'b0;
    for (int k = 1; k <= mx + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (done1) begin
        p1++;
        if (seen1 == 0) begin seen1 = k; cap1 = oval1; end
      end
      if (done4) begin
        p4++;
        if (seen4 == 0) begin seen4 = k; cap4 = oval4; end
      end
      // Operands are frozen after accept; scramble them to prove it.
      val  = $urandom;
      amt  = 5'($urandom_range(0, 31));
      mode = 2'($urandom_range(0, 3));
    end
    chk({name, " lat s1"}, 32'(seen1), 32'(lat1));
    chk({name, " lat s4"}, 32'(seen4), 32'(lat4));
    chk({name, " pulses s1"}, 32'(p1), 32'd1);
    chk({name, " pulses s4"}, 32'(p4), 32'd1);
    chk({name, " val s1"}, cap1, exp);
    chk({name, " val s4"}, cap4, exp);
    chk({name, " hold s1"}, oval1, exp);
    chk({name, " hold s4"}, oval4, exp);
  endtask

  initial begin
    logic [31:0] rv;
    logic [4:0]  rn;
    logic [1:0]  rm;

    tbl[0] = '{32'h0000_00F1,  5'd4, 2'b00, 32'h0000_0F10,  5, 2};
    tbl[1] = '{32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 32, 9};
    tbl[2] = '{32'h8000_0001,  5'd5, 2'b11, 32'h0000_0030,  6, 3};
    tbl[3] = '{32'hF000_0000,  5'd7, 2'b01, 32'h01E0_0000,  8, 3};
    tbl[4] = '{32'h1234_5678,  5'd0, 2'b01, 32'h1234_5678,  1, 1};
    tbl[5] = '{32'h1234_5678,  5'd8, 2'b11, 32'h3456_7812,  9, 3};
    tbl[6] = '{32'h7000_0000,  5'd3, 2'b10, 32'h0E00_0000,  4, 2};

    rst = 1'b1; start1 = 1'b0; start4 = 1'b0;
    val = '0; amt = '0; mode = '0;

    // Reset
    repeat (2) @(negedge clk);
    chk("reset val s1", oval1, 32'h0);
    chk("reset busy s1", 32'(busy1), 32'h0);
    chk("reset done s1", 32'(done1), 32'h0);
    chk("reset val s4", oval4, 32'h0);
    chk("reset busy s4", 32'(busy4), 32'h0);
    chk("reset done s4", 32'(done4), 32'h0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++)
      run_op(tbl[i].v, tbl[i].n, tbl[i].m, tbl[i].exp, tbl[i].lat1, tbl[i].lat4,
             $sformatf("tbl%0d", i));

    // Busy collision on the STEP=1 instance: LSL 0xF1 by 4, done at T+5
    @(negedge clk);                                   // T
    val = 32'h0000_00F1; amt = 5'd4; mode = 2'b00; start1 = 1'b1;
    @(negedge clk);                                   // T+1
    start1 = 1'b0;
    chk("coll busy T+1", 32'(busy1), 32'h1);
    @(negedge clk);                                   // T+2, SHIFT
    val = 32'hFFFF_FFFF; amt = 5'd1; mode = 2'b11; start1 = 1'b1;
    @(negedge clk);                                   // T+3
    start1 = 1'b0;
    @(negedge clk);                                   // T+4
    chk("coll done T+4", 32'(done1), 32'h0);
    @(negedge clk);                                   // T+5, DONE
    chk("coll done T+5", 32'(done1), 32'h1);
    chk("coll val T+5", oval1, 32'h0000_0F10);
    val = 32'hFFFF_FFFF; amt = 5'd0; mode = 2'b11; start1 = 1'b1;
    @(negedge clk);                                   // T+6, IDLE
    chk("coll ignored busy", 32'(busy1), 32'h0);
    chk("coll ignored done", 32'(done1), 32'h0);
    chk("coll ignored val", oval1, 32'h0000_0F10);
    val = 32'h0000_0100; amt = 5'd2; mode = 2'b01; start1 = 1'b1;
    @(negedge clk);                                   // T+7
    start1 = 1'b0;
    chk("coll next busy", 32'(busy1), 32'h1);
    @(negedge clk);                                   // T+8
    chk("coll next done early", 32'(done1), 32'h0);
    @(negedge clk);                                   // T+9
    chk("coll next done", 32'(done1), 32'h1);
    chk("coll next val", oval1, 32'h0000_0040);
    @(negedge clk);

    // Abort: LSL 1 by 20, reset two cycles after accept
    val = 32'h0000_0001; amt = 5'd20; mode = 2'b00; start1 = 1'b1; start4 = 1'b1;
    @(negedge clk);                                   // T+1
    start1 = 1'b0; start4 = 1'b0;
    chk("abort busy s1", 32'(busy1), 32'h1);
    chk("abort busy s4", 32'(busy4), 32'h1);
    @(negedge clk);                                   // T+2
    rst = 1'b1;
    chk("abort pre done s1", 32'(done1), 32'h0);
    chk("abort pre done s4", 32'(done4), 32'h0);
    @(negedge clk);                                   // T+3
    rst = 1'b0;
    chk("abort val s1", oval1, 32'h0);
    chk("abort busy s1 after", 32'(busy1), 32'h0);
    chk("abort done s1", 32'(done1), 32'h0);
    chk("abort val s4", oval4, 32'h0);
    chk("abort busy s4 after", 32'(busy4), 32'h0);
    chk("abort done s4", 32'(done4), 32'h0);
    run_op(32'h0000_0001, 5'd20, 2'b00, 32'h0010_0000, 21, 6, "post abort");

    // Randomized against the bit-level model
    for (int i = 0; i < 40; i++) begin
      rv = $urandom;
      rn = 5'($urandom_range(0, 31));
      rm = 2'($urandom_range(0, 3));
      run_op(rv, rn, rm, model(rv, int'(rn), rm), 1 + int'(rn), 1 + (int'(rn) + 3) / 4,
             $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
